// File: rtl/z80fi_insn_collector_pkg.sv
// rtl/z80fi_insn_collector_pkg.sv - shared z80fi types: collector states, default length, register snapshot
package z80fi_insn_collector_pkg;

   localparam int Z80FI_MAX_LEN = 4;

   typedef logic [0:0] collect_state_t;
   localparam collect_state_t ST_IDLE    = 1'b0;
   localparam collect_state_t ST_COLLECT = 1'b1;

   typedef struct packed {
      logic [15:0] ip;
      logic [15:0] ix;
      logic [15:0] iy;
      logic [7:0]  a;
      logic [7:0]  f;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [7:0]  d;
      logic [7:0]  e;
      logic [7:0]  h;
      logic [7:0]  l;
   } reg_snap_t;

endpackage

// File: rtl/z80fi_reg_snapshot.sv
// rtl/z80fi_reg_snapshot.sv - load-enabled register-file snapshot bank
module z80fi_reg_snapshot
   import z80fi_insn_collector_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  reg_snap_t d,
   output reg_snap_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/z80fi_insn_collector.sv
// rtl/z80fi_insn_collector.sv - packs fetched instruction bytes and pre-execution registers into z80fi packets
module z80fi_insn_collector
   import z80fi_insn_collector_pkg::*;
#(
   parameter int MAX_LEN = Z80FI_MAX_LEN
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 insn_start,
   input  logic                 insn_byte_valid,
   input  logic [7:0]           insn_byte,
   input  logic                 insn_done,
   input  logic [15:0]          reg_ip,
   input  logic [15:0]          reg_ix,
   input  logic [15:0]          reg_iy,
   input  logic [7:0]           reg_a,
   input  logic [7:0]           reg_f,
   input  logic [7:0]           reg_b,
   input  logic [7:0]           reg_c,
   input  logic [7:0]           reg_d,
   input  logic [7:0]           reg_e,
   input  logic [7:0]           reg_h,
   input  logic [7:0]           reg_l,
   output logic                 z80fi_valid,
   output logic [8*MAX_LEN-1:0] z80fi_insn,
   output logic [2:0]           z80fi_insn_len,
   output logic [15:0]          z80fi_reg_ip_in,
   output logic [15:0]          z80fi_reg_ix_in,
   output logic [15:0]          z80fi_reg_iy_in,
   output logic [7:0]           z80fi_reg_a_in,
   output logic [7:0]           z80fi_reg_f_in,
   output logic [7:0]           z80fi_reg_b_in,
   output logic [7:0]           z80fi_reg_c_in,
   output logic [7:0]           z80fi_reg_d_in,
   output logic [7:0]           z80fi_reg_e_in,
   output logic [7:0]           z80fi_reg_h_in,
   output logic [7:0]           z80fi_reg_l_in,
   output logic                 err_overflow,
   output logic                 err_abort
);

   localparam int         BW      = 8 * MAX_LEN;
   localparam logic [2:0] MAX_CNT = 3'(MAX_LEN);

   collect_state_t state_q;
   logic [2:0]     cnt_q, cnt_app;
   logic [BW-1:0]  col_buf_q, col_buf_app;
   logic           ovf_app;
   logic           start_acc, append, commit;
   reg_snap_t      snap_live, snap_work, snap_commit;

   assign start_acc = insn_start & insn_byte_valid;
   assign append    = (state_q == ST_COLLECT) & insn_byte_valid & ~insn_start;
   assign commit    = (state_q == ST_COLLECT) & insn_done;

   assign snap_live = '{ip: reg_ip, ix: reg_ix, iy: reg_iy, a: reg_a, f: reg_f,
                        b: reg_b, c: reg_c, d: reg_d, e: reg_e, h: reg_h, l: reg_l};

   // Buffer as it stands after this cycle's byte, so a byte arriving with insn_done is committed too
   always_comb begin
      col_buf_app = col_buf_q;
      cnt_app     = cnt_q;
      ovf_app     = 1'b0;
      if (append) begin
         if (cnt_q >= MAX_CNT) begin
            ovf_app = 1'b1;
         end else begin
            for (int i = 0; i < MAX_LEN; i++)
               if (cnt_q == 3'(i))
                  col_buf_app[8*i +: 8] = insn_byte;
            cnt_app = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         col_buf_q      <= '0;
         z80fi_valid    <= 1'b0;
         z80fi_insn     <= '0;
         z80fi_insn_len <= '0;
         err_overflow   <= 1'b0;
         err_abort      <= 1'b0;
      end else begin
         z80fi_valid <= commit;
         err_abort   <= (state_q == ST_COLLECT) & start_acc & ~insn_done;
         if (commit) begin
            z80fi_insn     <= col_buf_app;
            z80fi_insn_len <= cnt_app;
         end
         if (start_acc) begin
            col_buf_q    <= {{(BW-8){1'b0}}, insn_byte};
            cnt_q        <= 3'd1;
            err_overflow <= 1'b0;
            state_q      <= ST_COLLECT;
         end else begin
            col_buf_q <= col_buf_app;
            cnt_q     <= cnt_app;
            if (ovf_app)
               err_overflow <= 1'b1;
            if (commit)
               state_q <= ST_IDLE;
         end
      end
   end

   // Working snapshot feeds the commit bank, so a back-to-back start cannot disturb a presented packet
   z80fi_reg_snapshot u_snap_work (
      .clk  (clk),
      .rst  (reset),
      .load (start_acc),
      .d    (snap_live),
      .q    (snap_work)
   );

   z80fi_reg_snapshot u_snap_commit (
      .clk  (clk),
      .rst  (reset),
      .load (commit),
      .d    (snap_work),
      .q    (snap_commit)
   );

   assign z80fi_reg_ip_in = snap_commit.ip;
   assign z80fi_reg_ix_in = snap_commit.ix;
   assign z80fi_reg_iy_in = snap_commit.iy;
   assign z80fi_reg_a_in  = snap_commit.a;
   assign z80fi_reg_f_in  = snap_commit.f;
   assign z80fi_reg_b_in  = snap_commit.b;
   assign z80fi_reg_c_in  = snap_commit.c;
   assign z80fi_reg_d_in  = snap_commit.d;
   assign z80fi_reg_e_in  = snap_commit.e;
   assign z80fi_reg_h_in  = snap_commit.h;
   assign z80fi_reg_l_in  = snap_commit.l;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// tb/tb_z80fi_insn_collector.sv - self-checking bench for z80fi_insn_collector
module tb_z80fi_insn_collector;

   localparam int MAX_LEN = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        insn_start = 1'b0, insn_byte_valid = 1'b0, insn_done = 1'b0;
   logic [7:0]  insn_byte = 8'h00;
   logic [15:0] reg_ip = 16'h0, reg_ix = 16'h0, reg_iy = 16'h0;
   logic [7:0]  reg_a = 8'h0, reg_f = 8'h0, reg_b = 8'h0, reg_c = 8'h0;
   logic [7:0]  reg_d = 8'h0, reg_e = 8'h0, reg_h = 8'h0, reg_l = 8'h0;

   logic                 z80fi_valid;
   logic [8*MAX_LEN-1:0] z80fi_insn;
   logic [2:0]           z80fi_insn_len;
   logic [15:0]          z80fi_reg_ip_in, z80fi_reg_ix_in, z80fi_reg_iy_in;
   logic [7:0]           z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_b_in, z80fi_reg_c_in;
   logic [7:0]           z80fi_reg_d_in, z80fi_reg_e_in, z80fi_reg_h_in, z80fi_reg_l_in;
   logic                 err_overflow, err_abort;

   int tests = 0;
   int fails = 0;

   z80fi_insn_collector #(.MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset),
      .insn_start(insn_start), .insn_byte_valid(insn_byte_valid),
      .insn_byte(insn_byte), .insn_done(insn_done),
      .reg_ip(reg_ip), .reg_ix(reg_ix), .reg_iy(reg_iy),
      .reg_a(reg_a), .reg_f(reg_f), .reg_b(reg_b), .reg_c(reg_c),
      .reg_d(reg_d), .reg_e(reg_e), .reg_h(reg_h), .reg_l(reg_l),
      .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
      .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ix_in(z80fi_reg_ix_in),
      .z80fi_reg_iy_in(z80fi_reg_iy_in),
      .z80fi_reg_a_in(z80fi_reg_a_in), .z80fi_reg_f_in(z80fi_reg_f_in),
      .z80fi_reg_b_in(z80fi_reg_b_in), .z80fi_reg_c_in(z80fi_reg_c_in),
      .z80fi_reg_d_in(z80fi_reg_d_in), .z80fi_reg_e_in(z80fi_reg_e_in),
      .z80fi_reg_h_in(z80fi_reg_h_in), .z80fi_reg_l_in(z80fi_reg_l_in),
      .err_overflow(err_overflow), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [111:0] live_regs();
      return {reg_ip, reg_ix, reg_iy, reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l};
   endfunction

   function automatic logic [111:0] out_regs();
      return {z80fi_reg_ip_in, z80fi_reg_ix_in, z80fi_reg_iy_in, z80fi_reg_a_in, z80fi_reg_f_in,
              z80fi_reg_b_in, z80fi_reg_c_in, z80fi_reg_d_in, z80fi_reg_e_in, z80fi_reg_h_in,
              z80fi_reg_l_in};
   endfunction

   // Reference model: an open instruction is a list of bytes plus the registers seen at its start
   bit           m_open = 0;
   byte unsigned m_bytes[$];
   logic [111:0] m_snap = '0;
   logic [111:0] m_psnap = '0;
   logic [31:0]  m_insn = '0;
   logic [2:0]   m_len = '0;
   bit           m_valid = 0, m_abort = 0, m_ovf = 0;

   function automatic logic [31:0] pack_bytes();
      logic [31:0] v = '0;
      foreach (m_bytes[i]) v = v | (32'(m_bytes[i]) << (8 * i));
      return v;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_open = 0; m_bytes = {}; m_snap = '0; m_psnap = '0; m_insn = '0; m_len = '0;
         m_valid = 0; m_abort = 0; m_ovf = 0;
      end else begin
         m_valid = 0;
         m_abort = 0;
         if (m_open && insn_byte_valid && !insn_start) begin
            if (m_bytes.size() < MAX_LEN) m_bytes.push_back(insn_byte);
            else m_ovf = 1;
         end
         if (m_open && insn_done) begin
            m_valid = 1;
            m_insn  = pack_bytes();
            m_len   = 3'(m_bytes.size());
            m_psnap = m_snap;
            m_open  = 0;
         end
         if (insn_start && insn_byte_valid) begin
            if (m_open) m_abort = 1;
            m_bytes = {};
            m_bytes.push_back(insn_byte);
            m_snap = live_regs();
            m_ovf  = 0;
            m_open = 1;
         end
      end
      #1;
      chk("model_valid", z80fi_valid, m_valid);
      chk("model_abort", err_abort, m_abort);
      chk("model_overflow", err_overflow, m_ovf);
      chk("model_insn", z80fi_insn, m_insn);
      chk("model_len", z80fi_insn_len, m_len);
      chk("model_snapshot", out_regs(), m_psnap);
   end

   // Called at a falling edge; returns at the next falling edge with the posedge's effects visible
   task automatic step(input logic s, input logic v, input logic [7:0] b, input logic d);
      insn_start = s; insn_byte_valid = v; insn_byte = b; insn_done = d;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reg_a = 8'h11; reg_f = 8'h22; reg_b = 8'h33; reg_c = 8'h44;
      reg_d = 8'h55; reg_e = 8'h66; reg_h = 8'h77; reg_l = 8'h88;
      #1;
      chk("reset_valid", z80fi_valid, 1'b0);
      chk("reset_insn", z80fi_insn, 32'h0);
      chk("reset_flags", {err_overflow, err_abort, z80fi_insn_len}, 5'h0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      step(0, 0, 8'h00, 0);

      // LD (IX+5),B
      reg_ip = 16'h0200; reg_ix = 16'h1000;
      step(1, 1, 8'hDD, 0);
      step(0, 1, 8'h70, 0);
      step(0, 1, 8'h05, 1);
      chk("ldix_valid", z80fi_valid, 1'b1);
      chk("ldix_insn", z80fi_insn, 32'h000570DD);
      chk("ldix_len", z80fi_insn_len, 3'd3);
      chk("ldix_ip", z80fi_reg_ip_in, 16'h0200);
      chk("ldix_ix", z80fi_reg_ix_in, 16'h1000);
      chk("ldix_b", z80fi_reg_b_in, 8'h33);
      step(0, 0, 8'h00, 0);
      chk("ldix_pulse_width", z80fi_valid, 1'b0);

      // LD (IY-2),A with ip moving after the start cycle
      reg_ip = 16'h0201; reg_iy = 16'h2000;
      step(1, 1, 8'hFD, 0);
      reg_ip = 16'h0203;
      step(0, 1, 8'h77, 0);
      step(0, 1, 8'hFE, 1);
      chk("ldiy_insn", z80fi_insn, 32'h00FE77FD);
      chk("ldiy_len", z80fi_insn_len, 3'd3);
      chk("ldiy_ip", z80fi_reg_ip_in, 16'h0201);
      step(0, 0, 8'h00, 0);

      // Back-to-back: NOP retires while DD E5 starts
      reg_ip = 16'h0210;
      step(1, 1, 8'h00, 0);
      reg_ip = 16'h0300; reg_a = 8'h5A;
      step(1, 1, 8'hDD, 1);
      chk("b2b_first_valid", z80fi_valid, 1'b1);
      chk("b2b_first_insn", z80fi_insn, 32'h0);
      chk("b2b_first_len", z80fi_insn_len, 3'd1);
      chk("b2b_first_ip", z80fi_reg_ip_in, 16'h0210);
      chk("b2b_first_a", z80fi_reg_a_in, 8'h11);
      step(0, 1, 8'hE5, 1);
      chk("b2b_second_valid", z80fi_valid, 1'b1);
      chk("b2b_second_insn", z80fi_insn, 32'h0000E5DD);
      chk("b2b_second_len", z80fi_insn_len, 3'd2);
      chk("b2b_second_ip", z80fi_reg_ip_in, 16'h0300);
      chk("b2b_second_a", z80fi_reg_a_in, 8'h5A);
      step(0, 0, 8'h00, 0);

      // Overflow: fifth byte is dropped
      step(1, 1, 8'hDD, 0);
      step(0, 1, 8'hCB, 0);
      step(0, 1, 8'h05, 0);
      step(0, 1, 8'h46, 0);
      chk("ovf_not_yet", err_overflow, 1'b0);
      step(0, 1, 8'h99, 0);
      chk("ovf_set", err_overflow, 1'b1);
      step(0, 0, 8'h00, 1);
      chk("ovf_insn", z80fi_insn, 32'h4605CBDD);
      chk("ovf_len", z80fi_insn_len, 3'd4);
      step(0, 0, 8'h00, 0);
      chk("ovf_sticky", err_overflow, 1'b1);
      step(1, 1, 8'h00, 0);
      chk("ovf_cleared", err_overflow, 1'b0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Abort: a second start with no retire
      step(1, 1, 8'h3E, 0);
      step(1, 1, 8'h06, 0);
      chk("abort_pulse", err_abort, 1'b1);
      chk("abort_no_valid", z80fi_valid, 1'b0);
      step(0, 0, 8'h00, 0);
      chk("abort_one_cycle", err_abort, 1'b0);
      step(0, 0, 8'h00, 1);
      chk("abort_later_valid", z80fi_valid, 1'b1);
      chk("abort_later_insn", z80fi_insn, 32'h00000006);
      chk("abort_later_len", z80fi_insn_len, 3'd1);
      step(0, 0, 8'h00, 0);

      // Reset in the middle of collection
      step(1, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      reset = 1'b1;
      #1;
      chk("rst_mid_insn", z80fi_insn, 32'h0);
      chk("rst_mid_len", z80fi_insn_len, 3'd0);
      chk("rst_mid_snap", out_regs(), 112'h0);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 8'h00, 1);
      chk("rst_done_ignored", z80fi_valid, 1'b0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/z80fi_insn_collector.md
Name: z80fi_insn_collector

Overview:
- Upstream feeder of the z80fi instruction-spec checkers.
- Observes the core's opcode-fetch byte stream and retire strobe.
- Packs the 1-4 instruction bytes into z80fi_insn and z80fi_insn_len, and snapshots the pre-execution register file into the z80fi_reg_*_in fields.
- Emits a one-cycle z80fi_valid packet per retired instruction, which every z80fi_insn_spec_* module consumes directly.

Parameters:
MAX_LEN, 4, maximum instruction length in bytes; z80fi_insn width is 8*MAX_LEN.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
insn_start  in  1  first fetch byte of a new instruction is on insn_byte this cycle
insn_byte_valid  in  1  insn_byte carries a fetched instruction byte (prefix, opcode, displacement or immediate)
insn_byte  in  8  fetched byte
insn_done  in  1  current instruction retires this cycle
reg_ip, reg_ix, reg_iy  in  16 each  live register values
reg_a, reg_f, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l  in  8 each  live register values
z80fi_valid  out  1  one-cycle packet strobe
z80fi_insn  out  8*MAX_LEN  packed bytes; byte n at [8n+7:8n]
z80fi_insn_len  out  3  byte count, 1..MAX_LEN
z80fi_reg_ip_in, z80fi_reg_ix_in, z80fi_reg_iy_in  out  16 each  snapshot taken at insn_start
z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_b_in, z80fi_reg_c_in, z80fi_reg_d_in, z80fi_reg_e_in, z80fi_reg_h_in, z80fi_reg_l_in  out  8 each  snapshot taken at insn_start
err_overflow  out  1  sticky: more than MAX_LEN bytes in the current instruction
err_abort  out  1  one-cycle pulse: insn_start arrived with no retire of the open instruction

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0, including err_overflow and err_abort. Working buffers are cleared. Any in-flight instruction is discarded and no packet is emitted.
- States: IDLE, COLLECT.
- IDLE:
  - insn_start&insn_byte_valid: buf=0; buf[7:0]=insn_byte; cnt=1; register snapshot latched from reg_*; err_overflow cleared; go to COLLECT.
  - insn_start without insn_byte_valid is ignored.
  - insn_done is ignored.
- COLLECT:
  - insn_byte_valid & !insn_start: byte written to buf[8*cnt+7:8*cnt]; cnt++.
  - If cnt==MAX_LEN, the byte is dropped, cnt saturates and err_overflow is set (sticky until the next accepted insn_start or reset).
  - insn_done: the packet is committed. Next cycle z80fi_valid=1 and z80fi_insn/len/reg_*_in present the committed values. State returns to IDLE.
  - A byte with insn_byte_valid in the same cycle as insn_done belongs to the retiring instruction (appended first).
  - insn_done & insn_start in the same cycle: back-to-back case. The old instruction commits. The start byte opens a new buffer with a fresh snapshot. State stays COLLECT. No bubble.
  - insn_start without insn_done: the open instruction is discarded (no packet), err_abort pulses next cycle, and the new instruction opens as from IDLE.
- Latency: z80fi_valid follows insn_done by exactly 1 cycle and lasts 1 cycle.
- Packet outputs hold their last values until the next commit. Consumers must qualify them with z80fi_valid.
- Unused upper bytes of z80fi_insn are 0.
- z80fi_insn_len is never 0 on a valid packet.
- Snapshot values are those present on reg_* in the insn_start cycle, not at retire.
- The commit register is separate from the collection buffer, so back-to-back instructions never corrupt a presented packet.

Decomposition:
- Shared z80fi package: the collector state enum, MAX_LEN default, and the register-snapshot struct (ip, ix, iy, a, f, b, c, d, e, h, l) used by both collector and spec checkers.
- One natural sub-module: z80fi_reg_snapshot, a load-enabled register bank with async reset, instantiated twice: working snapshot and committed snapshot.

Test Plan:
- LD (IX+5),B with reg_ix=0x1000, reg_ip=0x0200: start+DD, then 70, 05, done -> next cycle z80fi_valid=1, z80fi_insn=0x000570DD, len=3, ip_in=0x0200, ix_in=0x1000.
- LD (IY-2),A: FD 77 FE, with reg_ip changed to 0x0203 in the byte-2 cycle -> insn=0x00FE77FD, len=3, ip_in holds the insn_start value.
- Back-to-back: NOP (00) retires in the same cycle as start+DD of the next instruction -> two consecutive valid pulses; the first has insn=0x00000000, len=1; the second has correct bytes and a fresh snapshot.
- Overflow: start+DD, CB, 05, 46, 99, done -> insn=0x4605CBDD, len=4, err_overflow=1; cleared on the next accepted insn_start.
- Abort: start+3E, then start+06 with no done -> err_abort pulses once, no z80fi_valid; a later done yields insn=0x06, len=1.
- Reset mid-COLLECT after 2 bytes -> all outputs 0 immediately; a subsequent done produces no packet.
